// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory block port between the I-cache and D-cache engines.
// Round-robin on simultaneous requests; one block transfer in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ack,
  output logic [BLOCK_W-1:0] i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic               d_ack,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic               i_busy,
  output logic               d_busy,
  output logic               timeout_err
);

  // state | meaning
  // IDLE  | sample requests, grant one
  // ISSUE | mem_req held, waiting for mem_ready
  // RESP  | ack pulse to the granted side
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic       grant;      // 0 = I side, 1 = D side; doubles as last_grant
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       pick_d;

  // D wins when it is the only requester, or on a tie when I was served last
  assign pick_d   = d_req & (~i_req | ~grant);
  assign wait_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  assign i_busy = i_req | (~grant & (state != IDLE));
  assign d_busy = d_req | ( grant & (state != IDLE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      wait_cnt    <= 8'd0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            grant     <= pick_d;
            mem_req   <= 1'b1;
            mem_we    <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : i_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            wait_cnt  <= 8'd0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= wait_nxt;
          if (wait_nxt >= TIMEOUT_CNT) timeout_err <= 1'b1;
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              if (grant) d_rdata <= mem_rdata;
              else       i_rdata <= mem_rdata;
            end
            if (grant) d_ack <= 1'b1;
            else       i_ack <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int BW = 128;
  localparam int TO = 10;

  logic          clock, reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [BW-1:0] d_wdata;
  logic          i_ack, d_ack;
  logic [BW-1:0] i_rdata, d_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          i_busy, d_busy, timeout_err;

  mem_port_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .i_busy(i_busy), .d_busy(d_busy), .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mem_fn(input logic [AW-1:0] a);
    return {4{a ^ 32'hA5A5_A4A5}};
  endfunction

  // memory responder: raises mem_ready after mem_delay waiting cycles unless held off
  int mem_delay = 0;
  bit mem_hold  = 0;
  int mem_wait  = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (mem_req && !mem_ready) begin
        mem_wait++;
        if (!mem_hold && mem_wait > mem_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_fn(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        mem_wait  = 0;
      end
    end
  end

  // transaction-level model: one record for the transfer in flight, edge arithmetic for ack timing
  int            cyc = 0;
  bit            m_active, m_side, m_last, m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wdata, m_ird, m_drd;
  int            m_n, m_next, m_ack_edge;
  bit            m_log[$];

  task automatic model_reset();
    m_active = 0; m_side = 0; m_last = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
    m_n = 0; m_next = 0; m_ack_edge = -10;
  endtask

  task automatic model_step();
    bit side;
    cyc++;
    if (m_active) begin
      m_n++;
      if (m_n >= TO) m_err = 1;
      if (mem_ready) begin
        m_active   = 0;
        m_ack_edge = cyc;
        m_next     = cyc + 2;
        if (!m_we) begin
          if (m_side) m_drd = mem_rdata;
          else        m_ird = mem_rdata;
        end
      end
    end else if (cyc >= m_next && (i_req || d_req)) begin
      side     = (i_req && d_req) ? !m_last : d_req;
      m_last   = side;
      m_side   = side;
      m_we     = side && d_we;
      m_addr   = side ? d_addr : i_addr;
      m_wdata  = d_wdata;
      m_active = 1;
      m_n      = 0;
      m_log.push_back(side);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // every-cycle compare against the model
  initial begin
    bit ack_now, inflight;
    forever begin
      @(negedge clock);
      ack_now  = (cyc == m_ack_edge);
      inflight = m_active || ack_now;
      check("i_ack", i_ack, ack_now && !m_side);
      check("d_ack", d_ack, ack_now && m_side);
      check("mem_req", mem_req, m_active);
      check("timeout_err", timeout_err, m_err);
      check("i_busy", i_busy, i_req || (inflight && !m_side));
      check("d_busy", d_busy, d_req || (inflight && m_side));
      check("i_rdata", i_rdata, m_ird);
      check("d_rdata", d_rdata, m_drd);
      if (m_active) begin
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // observation log of DUT acks and of each issued memory request
  int            ncyc = 0;
  bit            ack_q[$];
  int            ackt_q[$];
  logic [AW-1:0] cap_addr;
  logic [BW-1:0] cap_wdata;
  logic          cap_we;
  logic          prev_req = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      ncyc++;
      if (i_ack) begin ack_q.push_back(1'b0); ackt_q.push_back(ncyc); end
      if (d_ack) begin ack_q.push_back(1'b1); ackt_q.push_back(ncyc); end
      if (mem_req && !prev_req) begin
        cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
      end
      prev_req = mem_req;
    end
  end

  task automatic wait_acks(input int n, input int budget, input string nm);
    int k = 0;
    while (ack_q.size() < n && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    check(nm, ack_q.size() >= n, 1'b1);
  endtask

  task automatic clear_logs();
    ack_q.delete(); ackt_q.delete(); m_log.delete();
  endtask

  task automatic reset_pulse();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [BW-1:0] exp_blk;
    logic [BW-1:0] wb;
    bit exp_order[4];
    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_err", timeout_err, 1'b0);
    reset = 1'b1;

    // 1: I only, zero-wait memory
    clear_logs();
    @(posedge clock); #1;
    i_addr = 32'h100; i_req = 1;
    t0 = ncyc;
    wait_acks(1, 20, "t1_ack_seen");
    @(posedge clock); #1 i_req = 0;
    check("t1_latency", ackt_q[0] - t0, 3);
    check("t1_mem_addr", cap_addr, 32'h100);
    check("t1_mem_we", cap_we, 1'b0);
    exp_blk = {4{32'hA5A5_A5A5}};
    check("t1_i_rdata", i_rdata, exp_blk);

    // 2: simultaneous just after reset -> D first (write), then I
    reset_pulse();
    clear_logs();
    wb = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    @(posedge clock); #1;
    d_we = 1; d_addr = 32'h200; d_wdata = wb; i_addr = 32'h300;
    i_req = 1; d_req = 1;
    wait_acks(1, 20, "t2_first_ack");
    check("t2_first_is_d", ack_q[0], 1'b1);
    check("t2_mem_we", cap_we, 1'b1);
    check("t2_mem_addr", cap_addr, 32'h200);
    check("t2_mem_wdata", cap_wdata, wb);
    @(posedge clock); #1;
    d_req = 0; d_we = 0;
    wait_acks(2, 20, "t2_second_ack");
    @(posedge clock); #1 i_req = 0;
    check("t2_second_is_i", ack_q[1], 1'b0);
    check("t2_spacing", ackt_q[1] - ackt_q[0], 3);
    check("t2_i_rdata", i_rdata, mem_fn(32'h300));

    // 3: both held for four transfers -> D,I,D,I
    clear_logs();
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clock); #1;
    d_we = 0; d_addr = 32'h240; i_addr = 32'h340;
    i_req = 1; d_req = 1;
    wait_acks(4, 40, "t3_four_acks");
    @(posedge clock); #1;
    i_req = 0; d_req = 0;
    for (int k = 0; k < 4; k++) begin
      check("t3_dut_order", ack_q[k], exp_order[k]);
      check("t3_model_order", m_log[k], exp_order[k]);
      if (k > 0) check("t3_spacing", ackt_q[k] - ackt_q[k-1], 3);
    end
    check("t3_d_rdata", d_rdata, mem_fn(32'h240));

    // 4: memory answers after 5 waiting cycles
    clear_logs();
    mem_delay = 5;
    @(posedge clock); #1;
    i_addr = 32'h440; i_req = 1;
    t0 = ncyc;
    wait_acks(1, 30, "t4_ack_seen");
    @(posedge clock); #1 i_req = 0;
    check("t4_latency", ackt_q[0] - t0, 8);
    check("t4_single_ack", ack_q.size(), 1);
    mem_delay = 0;

    // 5: mem_ready withheld past TIMEOUT
    clear_logs();
    mem_hold = 1;
    @(posedge clock); #1;
    d_we = 1; d_addr = 32'h500; d_wdata = ~wb; d_req = 1;
    t0 = ncyc;
    while (ncyc < t0 + 11) begin @(negedge clock); #1; end
    check("t5_err_before", timeout_err, 1'b0);
    @(negedge clock); #1;
    check("t5_err_after", timeout_err, 1'b1);
    mem_hold = 0;
    wait_acks(1, 20, "t5_ack_seen");
    @(posedge clock); #1;
    d_req = 0; d_we = 0;
    repeat (3) @(posedge clock);
    #1 check("t5_err_sticky", timeout_err, 1'b1);

    // 6: reset in the middle of ISSUE
    clear_logs();
    mem_hold = 1;
    @(posedge clock); #1;
    i_addr = 32'h600; i_req = 1;
    repeat (3) @(negedge clock);
    #1 check("t6_in_issue", mem_req, 1'b1);
    #2;
    reset = 1'b0; i_req = 0;
    #1;
    check("t6_rst_mem_req", mem_req, 1'b0);
    check("t6_rst_i_ack", i_ack, 1'b0);
    check("t6_rst_err", timeout_err, 1'b0);
    mem_hold = 0;
    @(posedge clock); #1 reset = 1'b1;
    clear_logs();
    @(posedge clock); #1;
    i_addr = 32'h700; i_req = 1;
    t0 = ncyc;
    wait_acks(1, 20, "t6_ack_seen");
    @(posedge clock); #1 i_req = 0;
    check("t6_latency", ackt_q[0] - t0, 3);
    exp_blk = {4{32'hA5A5_A3A5}};
    check("t6_i_rdata", i_rdata, exp_blk);

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
